event_detector: RTL and testbench
=================================

EVENT_DETECTOR -- requirements
Module: event_detector

Interface
REQ-001 Parameter THRESHOLD, default 16: detection level on the 7-bit channel sample.
REQ-002 Parameter HYST, default 4: release hysteresis; legal range 0 <= HYST <= THRESHOLD.
REQ-003 Parameter MIN_LEN, default 3: consecutive above-threshold samples needed to declare detection; legal range 2..15.
REQ-004 Parameter TS_W, default 8: timestamp width.
REQ-005 Clock: input_acquisition_clk, input, 1. Single clock for all logic.
REQ-006 Reset: reset, input, 1. Synchronous, active-high.
REQ-007 RTC_clk, input, 1: raw real-time tick, asynchronous to input_acquisition_clk.
REQ-008 ch, input, 7: channel sample, one per clock.
REQ-009 event_ready, input, 1: downstream memorisation stage accepts the pending event.
REQ-010 signal_detected, output, 1: registered; high while in ACTIVE.
REQ-011 event_valid, output, 1: event record pending.
REQ-012 event_time, output, TS_W: timestamp latched at event start.
REQ-013 event_peak, output, 7: maximum sample over the event.
REQ-014 overflow, output, 1: sticky; an event was dropped.

Function
REQ-015 RTC_clk passes through a 2-flop synchroniser plus 1 edge flop; rtc_rise = sync2 & ~edge.
REQ-016 Timestamp counter increments by 1 on each rtc_rise and wraps from 2^TS_W-1 to 0; it is updated 3 clocks after the RTC_clk rising edge is first sampled.
REQ-017 above = (ch >= THRESHOLD); below = (ch < THRESHOLD - HYST); unsigned 7-bit compare.
REQ-018 FSM states: IDLE, ARM, ACTIVE.
REQ-019 IDLE with above: go to ARM, len = 1, latch start_time = current timestamp, peak = ch.
REQ-020 ARM with above: len + 1, peak = max(peak, ch); when len + 1 == MIN_LEN, go to ACTIVE and set signal_detected on the same edge.
REQ-021 ARM without above: return to IDLE and discard the candidate; no event, no overflow.
REQ-022 ACTIVE without below: stay; peak = max(peak, ch).
- The sample that causes below is excluded from peak.
REQ-023 ACTIVE with below: return to IDLE, clear signal_detected, and complete the event.
REQ-024 Event completion when event_valid == 0, or when event_valid & event_ready in the same cycle: load event_time/event_peak and set event_valid on the next edge.
REQ-025 Event completion while event_valid & ~event_ready: new event dropped, pending record unchanged, overflow set to 1.
REQ-026 overflow is cleared only by reset.
REQ-027 Handshake: transfer occurs on an edge where event_valid & event_ready.
- event_valid falls on that edge unless REQ-024 reloads it.
- Record outputs are stable while event_valid & ~event_ready.
REQ-028 The timestamp keeps counting in all FSM states.
REQ-029 A simultaneous rtc_rise and IDLE->ARM transition latches the pre-increment timestamp.

Reset
REQ-030 On reset (sampled high at a clock edge) all of the following are 0, effective the following cycle:
- FSM state to IDLE.
- Timestamp, len, peak, synchroniser flops.
- signal_detected, event_valid, event_time, event_peak, overflow.
REQ-031 Reset mid-event discards the candidate or active event without emitting it.

Configuration
REQ-032 Macro EVENT_DURATION_EN.
- Defined: adds output event_duration, 8 bits. It counts samples from the IDLE->ARM sample through the last non-below ACTIVE sample, saturates at 255, and is latched, held and reset with the other record fields.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Verification
REQ-033 All scenarios use default parameters.
- Reset: assert reset for 2 clocks -> all outputs 0, state IDLE.
- Short pulse: ch = 20, 20, 0 -> signal_detected stays 0, event_valid stays 0.
- Normal event: 5 RTC_clk pulses, then ch = 20, 30, 25, 14, 13, 11 with event_ready = 1.
  - signal_detected rises after the third sample and falls after the sample 11.
  - event_valid is high for 1 cycle with event_time = 5, event_peak = 30.
  - event_duration = 5 when EVENT_DURATION_EN is defined.
- Backpressure: event_ready = 0, two complete events (peaks 30, then 40) -> event_peak holds 30, overflow = 1.
  - Then raise event_ready -> one transfer, event_valid falls.
- Wrap: 256 RTC_clk pulses from reset -> timestamp reads 0.
- Reset mid-ACTIVE: reset after ch = 20, 30, 25 -> signal_detected = 0, no event emitted afterwards.

Source files
------------

// File: rtl/event_detector_if.sv
// event_detector_if: event record handshake (valid/ready plus record fields); EVENT_DURATION_EN adds event_duration
interface event_detector_if #(
   parameter int TS_W = 8
);
   logic            event_valid;
   logic            event_ready;
   logic [TS_W-1:0] event_time;
   logic [6:0]      event_peak;
`ifdef EVENT_DURATION_EN
   logic [7:0]      event_duration;
`endif

`ifdef EVENT_DURATION_EN
   modport master (output event_valid, event_time, event_peak, event_duration, input event_ready);
   modport slave  (input event_valid, event_time, event_peak, event_duration, output event_ready);
`else
   modport master (output event_valid, event_time, event_peak, input event_ready);
   modport slave  (input event_valid, event_time, event_peak, output event_ready);
`endif
endinterface

// File: rtl/event_detector.sv
// event_detector: threshold/hysteresis event detector with RTC timestamping; EVENT_DURATION_EN adds event_duration
module event_detector #(
   parameter int THRESHOLD = 16,
   parameter int HYST      = 4,
   parameter int MIN_LEN   = 3,
   parameter int TS_W      = 8
) (
   input  logic                input_acquisition_clk,
   input  logic                reset,
   input  logic                RTC_clk,
   input  logic [6:0]          ch,
   output logic                signal_detected,
   output logic                overflow,
   event_detector_if.master    ev
);
   typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

   localparam logic [6:0] THR = 7'(THRESHOLD);
   localparam logic [6:0] REL = 7'(THRESHOLD - HYST);

   state_t          state_q, state_d;
   logic            s1_q, s2_q, edge_q;
   logic [TS_W-1:0] ts_q, ts_d, start_q, start_d, time_q, time_d;
   logic [3:0]      len_q, len_d;
   logic [6:0]      peak_q, peak_d, epeak_q, epeak_d, peak_max;
   logic            det_q, det_d, valid_q, valid_d, ovf_q, ovf_d;
   logic            rtc_rise, above, below, complete;
   logic [7:0]      dur_q, dur_d, edur_q, edur_d;

   assign rtc_rise = s2_q & ~edge_q;
   assign above    = ch >= THR;
   assign below    = ch < REL;
   assign peak_max = (ch > peak_q) ? ch : peak_q;

   // Timestamp and detection FSM next state
   always_comb begin
      ts_d     = ts_q + TS_W'(rtc_rise);
      state_d  = state_q;
      len_d    = len_q;
      peak_d   = peak_q;
      start_d  = start_q;
      det_d    = det_q;
      dur_d    = dur_q;
      complete = 1'b0;
      case (state_q)
         IDLE: if (above) begin
            state_d = ARM;
            len_d   = 4'd1;
            start_d = ts_q;
            peak_d  = ch;
            dur_d   = 8'd1;
         end
         ARM: if (above) begin
            len_d  = len_q + 4'd1;
            peak_d = peak_max;
            dur_d  = dur_q + 8'd1;
            if (len_q + 4'd1 == 4'(MIN_LEN)) begin
               state_d = ACTIVE;
               det_d   = 1'b1;
            end
         end else state_d = IDLE;
         ACTIVE: if (below) begin
            state_d  = IDLE;
            det_d    = 1'b0;
            complete = 1'b1;
         end else begin
            peak_d = peak_max;
            dur_d  = (dur_q == 8'hff) ? dur_q : dur_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output record: load on completion when the slot frees this cycle, otherwise drop and flag overflow
   always_comb begin
      valid_d = valid_q & ~ev.event_ready;
      time_d  = time_q;
      epeak_d = epeak_q;
      edur_d  = edur_q;
      ovf_d   = ovf_q;
      if (complete && (!valid_q || ev.event_ready)) begin
         valid_d = 1'b1;
         time_d  = start_q;
         epeak_d = peak_q;
         edur_d  = dur_q;
      end else if (complete) ovf_d = 1'b1;
   end

   // State registers, synchroniser included
   always_ff @(posedge input_acquisition_clk) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         edge_q  <= 1'b0;
         ts_q    <= '0;
         state_q <= IDLE;
         len_q   <= '0;
         peak_q  <= '0;
         start_q <= '0;
         det_q   <= 1'b0;
         dur_q   <= '0;
         valid_q <= 1'b0;
         time_q  <= '0;
         epeak_q <= '0;
         edur_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         s1_q    <= RTC_clk;
         s2_q    <= s1_q;
         edge_q  <= s2_q;
         ts_q    <= ts_d;
         state_q <= state_d;
         len_q   <= len_d;
         peak_q  <= peak_d;
         start_q <= start_d;
         det_q   <= det_d;
         dur_q   <= dur_d;
         valid_q <= valid_d;
         time_q  <= time_d;
         epeak_q <= epeak_d;
         edur_q  <= edur_d;
         ovf_q   <= ovf_d;
      end
   end

   assign signal_detected = det_q;
   assign overflow        = ovf_q;
   assign ev.event_valid  = valid_q;
   assign ev.event_time   = time_q;
   assign ev.event_peak   = epeak_q;
`ifdef EVENT_DURATION_EN
   assign ev.event_duration = edur_q;
`endif
endmodule

// File: tb/tb_event_detector.sv
// tb_event_detector: directed self-checking bench for event_detector (default parameters)
module tb_event_detector;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rtc = 1'b0;
   logic [6:0] ch = '0;
   logic       sd, ovf;
   int         checks = 0;
   int         failures = 0;

   event_detector_if #(.TS_W(8)) ev();

   event_detector dut (
      .input_acquisition_clk(clk),
      .reset(reset),
      .RTC_clk(rtc),
      .ch(ch),
      .signal_detected(sd),
      .overflow(ovf),
      .ev(ev)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      ch = '0;
      rtc = 1'b0;
      ev.event_ready = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic rtc_pulses(input int n);
      repeat (n) begin
         rtc = 1'b1;
         tick(2);
         rtc = 1'b0;
         tick(2);
      end
      tick(4);
   endtask

   task automatic feed(input logic [6:0] v);
      ch = v;
      tick(1);
   endtask

   task automatic test_reset;
      do_reset;
      rtc_pulses(3);
      feed(20); feed(30); feed(25); feed(11);
      do_reset;
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL reset_sd got=%0b exp=0", sd); end
      checks++; if (ev.event_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ev.event_valid); end
      checks++; if (ev.event_time !== 8'd0) begin failures++; $display("FAIL reset_time got=%0d exp=0", ev.event_time); end
      checks++; if (ev.event_peak !== 7'd0) begin failures++; $display("FAIL reset_peak got=%0d exp=0", ev.event_peak); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
`ifdef EVENT_DURATION_EN
      checks++; if (ev.event_duration !== 8'd0) begin failures++; $display("FAIL reset_dur got=%0d exp=0", ev.event_duration); end
`endif
   endtask

   task automatic test_short_pulse;
      do_reset;
      ev.event_ready = 1'b1;
      feed(20);
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL short_sd1 got=%0b exp=0", sd); end
      feed(20);
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL short_sd2 got=%0b exp=0", sd); end
      feed(0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (sd !== 1'b0 || ev.event_valid !== 1'b0) begin failures++; $display("FAIL short_idle%0d got sd=%0b valid=%0b exp=0/0", i, sd, ev.event_valid); end
         tick(1);
      end
   endtask

   task automatic test_normal;
      do_reset;
      rtc_pulses(5);
      ev.event_ready = 1'b1;
      feed(20);
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL normal_sd20 got=%0b exp=0", sd); end
      feed(30);
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL normal_sd30 got=%0b exp=0", sd); end
      feed(25);
      checks++; if (sd !== 1'b1) begin failures++; $display("FAIL normal_sd25 got=%0b exp=1", sd); end
      feed(14);
      checks++; if (sd !== 1'b1) begin failures++; $display("FAIL normal_sd14 got=%0b exp=1", sd); end
      feed(13);
      checks++; if (sd !== 1'b1 || ev.event_valid !== 1'b0) begin failures++; $display("FAIL normal_sd13 got sd=%0b valid=%0b exp=1/0", sd, ev.event_valid); end
      feed(11);
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL normal_sd11 got=%0b exp=0", sd); end
      checks++; if (ev.event_valid !== 1'b1) begin failures++; $display("FAIL normal_valid got=%0b exp=1", ev.event_valid); end
      checks++; if (ev.event_time !== 8'd5) begin failures++; $display("FAIL normal_time got=%0d exp=5", ev.event_time); end
      checks++; if (ev.event_peak !== 7'd30) begin failures++; $display("FAIL normal_peak got=%0d exp=30", ev.event_peak); end
`ifdef EVENT_DURATION_EN
      checks++; if (ev.event_duration !== 8'd5) begin failures++; $display("FAIL normal_dur got=%0d exp=5", ev.event_duration); end
`endif
      feed(0);
      checks++; if (ev.event_valid !== 1'b0) begin failures++; $display("FAIL normal_valid_fall got=%0b exp=0", ev.event_valid); end
   endtask

   task automatic test_backpressure;
      do_reset;
      feed(20); feed(30); feed(25); feed(11);
      checks++; if (ev.event_valid !== 1'b1 || ev.event_peak !== 7'd30) begin failures++; $display("FAIL bp_first got valid=%0b peak=%0d exp=1/30", ev.event_valid, ev.event_peak); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf_early got=%0b exp=0", ovf); end
      feed(0); feed(0);
      feed(20); feed(40); feed(25); feed(11);
      checks++; if (ev.event_valid !== 1'b1 || ev.event_peak !== 7'd30) begin failures++; $display("FAIL bp_hold got valid=%0b peak=%0d exp=1/30", ev.event_valid, ev.event_peak); end
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%0b exp=1", ovf); end
      checks++; if (ev.event_time !== 8'd0) begin failures++; $display("FAIL bp_time got=%0d exp=0", ev.event_time); end
      ch = 0;
      ev.event_ready = 1'b1;
      tick(1);
      checks++; if (ev.event_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", ev.event_valid); end
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%0b exp=1", ovf); end
   endtask

   task automatic test_boundary;
      do_reset;
      ev.event_ready = 1'b1;
      feed(15); feed(15); feed(15);
      checks++; if (sd !== 1'b0 || ev.event_valid !== 1'b0) begin failures++; $display("FAIL bnd_15 got sd=%0b valid=%0b exp=0/0", sd, ev.event_valid); end
      feed(16); feed(16);
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL bnd_16x2 got=%0b exp=0", sd); end
      feed(16);
      checks++; if (sd !== 1'b1) begin failures++; $display("FAIL bnd_16x3 got=%0b exp=1", sd); end
      feed(12);
      checks++; if (sd !== 1'b1) begin failures++; $display("FAIL bnd_12 got=%0b exp=1", sd); end
      feed(11);
      checks++; if (sd !== 1'b0 || ev.event_valid !== 1'b1 || ev.event_peak !== 7'd16) begin failures++; $display("FAIL bnd_11 got sd=%0b valid=%0b peak=%0d exp=0/1/16", sd, ev.event_valid, ev.event_peak); end
`ifdef EVENT_DURATION_EN
      checks++; if (ev.event_duration !== 8'd4) begin failures++; $display("FAIL bnd_dur got=%0d exp=4", ev.event_duration); end
`endif
      feed(0);
   endtask

   task automatic test_wrap;
      do_reset;
      ev.event_ready = 1'b1;
      rtc_pulses(255);
      feed(20); feed(30); feed(25); feed(11);
      checks++; if (ev.event_valid !== 1'b1 || ev.event_time !== 8'd255) begin failures++; $display("FAIL wrap_255 got valid=%0b time=%0d exp=1/255", ev.event_valid, ev.event_time); end
      feed(0);
      rtc_pulses(1);
      feed(20); feed(30); feed(25); feed(11);
      checks++; if (ev.event_valid !== 1'b1 || ev.event_time !== 8'd0) begin failures++; $display("FAIL wrap_0 got valid=%0b time=%0d exp=1/0", ev.event_valid, ev.event_time); end
      feed(0);
   endtask

   task automatic test_reset_mid;
      do_reset;
      ev.event_ready = 1'b1;
      feed(20); feed(30); feed(25);
      checks++; if (sd !== 1'b1) begin failures++; $display("FAIL mid_active got=%0b exp=1", sd); end
      reset = 1'b1;
      ch = 30;
      tick(1);
      reset = 1'b0;
      checks++; if (sd !== 1'b0) begin failures++; $display("FAIL mid_sd got=%0b exp=0", sd); end
      feed(25); feed(11);
      for (int i = 0; i < 3; i++) begin
         checks++; if (sd !== 1'b0 || ev.event_valid !== 1'b0) begin failures++; $display("FAIL mid_after%0d got sd=%0b valid=%0b exp=0/0", i, sd, ev.event_valid); end
         feed(0);
      end
   endtask

   initial begin
      ev.event_ready = 1'b0;
      test_reset;
      test_short_pulse;
      test_normal;
      test_backpressure;
      test_boundary;
      test_wrap;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
